// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Brief    : Instruction-memory request/response bus between the fetch
//             stage (master) and the instruction memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req_o;     // request strobe, one cycle per request
    logic [31:0] imem_addr_o;    // request address
    logic        imem_rvalid_i;  // response valid
    logic [31:0] imem_rdata_i;   // response instruction word

    // Fetch-stage view: drives the request, consumes the response.
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    // Memory view: consumes the request, drives the response.
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction-fetch stage and IF/ID pipeline register. Owns the
//             PC, keeps at most one request outstanding to a variable-latency
//             instruction memory, honours load-use stalls and EXE redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,            // asynchronous, active low
    fetch_stage_if.master    imem,
    input  wire logic        IF_redo,
    input  wire logic        ID_redo,
    input  wire logic        branch_taken_i,
    input  wire logic [31:0] branch_target_i,
    output logic      [31:0] IFID_pc_o,
    output logic      [31:0] IFID_pc4_o,
    output logic      [31:0] IFID_instr_o,
    output logic             IFID_valid_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // issue a request at pc
        S_WAIT = 2'd1,   // one request outstanding
        S_HOLD = 2'd2    // response parked in the hold buffer during a stall
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        drop_q;     // outstanding response belongs to a flushed path
    logic [31:0] hold_q;     // instruction captured while stalled

    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pc4_q;
    logic [31:0] ifid_instr_q;
    logic        ifid_valid_q;

    logic        stall;
    logic        redirect;
    logic [31:0] pc_plus4;

    // Hazard inputs and the modulo-2^32 sequential PC.
    always_comb begin
        stall    = IF_redo | ID_redo;
        redirect = branch_taken_i;
        pc_plus4 = pc_q + 32'd4;
    end

    // Request strobe: only from S_REQ, suppressed by a redirect and while reset is held.
    always_comb begin
        imem.imem_req_o  = rst_i && (state_q == S_REQ) && !redirect;
        imem.imem_addr_o = pc_q;
    end

    // Fetch FSM, PC, drop flag, hold buffer and the IF/ID register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RESET;
            drop_q       <= 1'b0;
            hold_q       <= NOP_INSTR;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            // IF/ID default: a flush on redirect, a bubble when not stalled,
            // otherwise hold. Deliveries below override the bubble.
            if (redirect || !stall) begin
                ifid_instr_q <= NOP_INSTR;
                ifid_valid_q <= 1'b0;
            end

            case (state_q)
                S_REQ: begin
                    // A response seen here is a leftover from before reset; ignore it.
                    if (redirect) begin
                        pc_q <= branch_target_i;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect) begin
                        pc_q <= branch_target_i;
                        if (imem.imem_rvalid_i) begin
                            // Stale response arrives with the redirect: discard now.
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            // Still in flight: remember to discard it on arrival.
                            drop_q <= 1'b1;
                        end
                    end else if (imem.imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!stall) begin
                            ifid_pc_q    <= pc_q;
                            ifid_pc4_q   <= pc_plus4;
                            ifid_instr_q <= imem.imem_rdata_i;
                            ifid_valid_q <= 1'b1;
                            pc_q         <= pc_plus4;
                            state_q      <= S_REQ;
                        end else begin
                            hold_q  <= imem.imem_rdata_i;
                            state_q <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc_q    <= branch_target_i;
                        state_q <= S_REQ;
                    end else if (!stall) begin
                        ifid_pc_q    <= pc_q;
                        ifid_pc4_q   <= pc_plus4;
                        ifid_instr_q <= hold_q;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= pc_plus4;
                        state_q      <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered IF/ID outputs.
    always_comb begin
        IFID_pc_o    = ifid_pc_q;
        IFID_pc4_o   = ifid_pc4_q;
        IFID_instr_o = ifid_instr_q;
        IFID_valid_o = ifid_valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Self-checking bench for fetch_stage: directed scenarios with
//             literal expectations, then randomized stalls, redirects and
//             memory latencies against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] XKEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_redo, id_redo, br_taken;
    logic [31:0] br_target;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
    logic        ifid_valid;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .imem            (imem),
        .IF_redo         (if_redo),
        .ID_redo         (id_redo),
        .branch_taken_i  (br_taken),
        .branch_target_i (br_target),
        .IFID_pc_o       (ifid_pc),
        .IFID_pc4_o      (ifid_pc4),
        .IFID_instr_o    (ifid_instr),
        .IFID_valid_o    (ifid_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory model: one pending response with a countdown.
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat;
    logic        rst_drv;

    // Reference model: fetch address, outstanding request, hold slot, IF/ID.
    logic [31:0] m_pc;
    bit          m_out, m_stale, m_held;
    logic [31:0] m_hinstr;
    logic [31:0] m_ipc, m_ipc4, m_iinstr;
    logic        m_ivalid;

    // Last observed request, for directed literal checks.
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_held = 0; m_hinstr = NOP;
        m_ipc = 32'h0; m_ipc4 = 32'h0; m_iinstr = NOP; m_ivalid = 1'b0;
        mem_pending = 0; mem_cnt = 0;
    endtask

    task automatic bubble_or_hold(input bit stall);
        if (!stall) begin
            m_iinstr = NOP;
            m_ivalid = 1'b0;
        end
    endtask

    task automatic deliver(input logic [31:0] instr);
        m_ipc    = m_pc;
        m_ipc4   = m_pc + 32'd4;
        m_iinstr = instr;
        m_ivalid = 1'b1;
        m_pc     = m_pc + 32'd4;
    endtask

    // One clock cycle: drive inputs, check the request, advance the model,
    // then check the IF/ID register after the edge.
    task automatic cycle(input logic br, input logic [31:0] tgt,
                         input logic ifr, input logic idr, input logic frv);
        logic        rv;
        logic [31:0] rd;
        bit          exp_req, stall;
        @(negedge clk);
        rst_n = rst_drv;
        rv = 1'b0;
        rd = $urandom;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rv = 1'b1;
                rd = mem_addr ^ XKEY;
                mem_pending = 0;
            end
        end
        if (frv) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        br_taken = br; br_target = tgt; if_redo = ifr; id_redo = idr;
        imem.imem_rvalid_i = rv; imem.imem_rdata_i = rd;
        #1;
        exp_req  = rst_n && !br && !m_out && !m_held;
        obs_req  = imem.imem_req_o;
        obs_addr = imem.imem_addr_o;
        chk("imem_req", {31'b0, obs_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", obs_addr, m_pc);
        if (!rst_n) begin
            model_reset();
        end else begin
            stall = ifr | idr;
            if (exp_req) begin
                mem_pending = 1; mem_cnt = lat; mem_addr = m_pc;
            end
            if (br) begin
                m_iinstr = NOP; m_ivalid = 1'b0;
                m_pc = tgt; m_held = 0;
                if (m_out && !rv) m_stale = 1;
                else begin m_out = 0; m_stale = 0; end
            end else if (exp_req) begin
                m_out = 1; m_stale = 0;
                bubble_or_hold(stall);
            end else if (m_out && rv) begin
                m_out = 0;
                if (m_stale) begin
                    m_stale = 0;
                    bubble_or_hold(stall);
                end else if (!stall) begin
                    deliver(rd);
                end else begin
                    m_held = 1; m_hinstr = rd;
                end
            end else if (m_held) begin
                if (!stall) begin
                    deliver(m_hinstr);
                    m_held = 0;
                end
            end else begin
                bubble_or_hold(stall);
            end
        end
        @(posedge clk);
        #1;
        chk("IFID_pc",    ifid_pc,    m_ipc);
        chk("IFID_pc4",   ifid_pc4,   m_ipc4);
        chk("IFID_instr", ifid_instr, m_iinstr);
        chk("IFID_valid", {31'b0, ifid_valid}, {31'b0, m_ivalid});
    endtask

    initial begin
        logic [31:0] t;
        int          r;
        rst_n = 1'b0; rst_drv = 1'b0; lat = 1;
        if_redo = 0; id_redo = 0; br_taken = 0; br_target = 0;
        imem.imem_rvalid_i = 0; imem.imem_rdata_i = 0;
        model_reset();

        // Reset
        cycle(0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0000_0013);
        cycle(0, 0, 0, 0, 0);
        rst_drv = 1'b1;

        // Free run, 1-cycle memory
        cycle(0, 0, 0, 0, 0);                     // c1
        chk("first_req", {31'b0, obs_req}, 32'd1);
        chk("first_addr", obs_addr, 32'h0);
        cycle(0, 0, 0, 0, 0);                     // c2
        chk("wait_noreq", {31'b0, obs_req}, 32'd0);
        chk("d0_pc", ifid_pc, 32'h0);
        chk("d0_instr", ifid_instr, 32'hA5A5_0000);
        chk("d0_valid", {31'b0, ifid_valid}, 32'd1);
        cycle(0, 0, 0, 0, 0);                     // c3
        chk("req4_addr", obs_addr, 32'h4);
        cycle(0, 0, 0, 0, 0);                     // c4
        cycle(0, 0, 0, 0, 0);                     // c5
        chk("req8_addr", obs_addr, 32'h8);

        // Load-use stall for two cycles while the response for 0x8 arrives
        cycle(0, 0, 1, 1, 0);                     // c6
        chk("stall1_noreq", {31'b0, obs_req}, 32'd0);
        chk("stall1_pc", ifid_pc, 32'h4);
        cycle(0, 0, 1, 1, 0);                     // c7
        chk("stall2_noreq", {31'b0, obs_req}, 32'd0);
        chk("stall2_pc", ifid_pc, 32'h4);
        cycle(0, 0, 0, 0, 0);                     // c8
        chk("unstall_pc", ifid_pc, 32'h8);
        chk("unstall_instr", ifid_instr, 32'hA5A5_0008);

        // Redirect while a 3-cycle request is outstanding
        lat = 3;
        cycle(0, 0, 0, 0, 0);                     // c9
        chk("reqC_addr", obs_addr, 32'hC);
        cycle(1, 32'h100, 0, 0, 0);               // c10
        chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flush_instr", ifid_instr, 32'h0000_0013);
        cycle(0, 0, 0, 0, 0);                     // c11
        lat = 1;
        cycle(0, 0, 0, 0, 0);                     // c12 stale response
        chk("stale_noreq", {31'b0, obs_req}, 32'd0);
        cycle(0, 0, 0, 0, 0);                     // c13
        chk("tgt_addr", obs_addr, 32'h100);
        cycle(0, 0, 0, 0, 0);                     // c14
        chk("tgt_pc", ifid_pc, 32'h100);

        // Redirect together with a stall while in S_HOLD
        cycle(0, 0, 0, 0, 0);                     // c15
        cycle(0, 0, 1, 0, 0);                     // c16
        cycle(1, 32'h200, 0, 1, 0);               // c17
        chk("hold_flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("hold_flush_instr", ifid_instr, 32'h0000_0013);
        cycle(0, 0, 0, 0, 0);                     // c18
        chk("hold_tgt_addr", obs_addr, 32'h200);
        cycle(0, 0, 0, 0, 0);                     // c19

        // PC wrap
        cycle(1, 32'hFFFF_FFFC, 0, 0, 0);         // c20
        chk("wrap_noreq", {31'b0, obs_req}, 32'd0);
        cycle(0, 0, 0, 0, 0);                     // c21
        chk("wrap_addr", obs_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0);                     // c22
        chk("wrap_pc4", ifid_pc4, 32'h0);
        cycle(0, 0, 0, 0, 0);                     // c23
        chk("wrap_next", obs_addr, 32'h0);
        lat = 3;
        cycle(0, 0, 0, 0, 0);                     // c24
        cycle(0, 0, 0, 0, 0);                     // c25 request 0x4
        cycle(0, 0, 0, 0, 0);                     // c26 in S_WAIT

        // Asynchronous reset mid-S_WAIT
        @(negedge clk);
        imem.imem_rvalid_i = 1'b0;
        #2;
        rst_n = 1'b0; rst_drv = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem.imem_req_o}, 32'd0);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_pc4", ifid_pc4, 32'h0);
        chk("arst_instr", ifid_instr, 32'h0000_0013);
        chk("arst_valid", {31'b0, ifid_valid}, 32'd0);
        model_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        rst_drv = 1'b1; lat = 1;
        cycle(0, 0, 0, 0, 1);                     // late response, ignored
        chk("arst_first_req", {31'b0, obs_req}, 32'd1);
        chk("arst_first_addr", obs_addr, 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("arst_d0_pc", ifid_pc, 32'h0);
        chk("arst_d0_instr", ifid_instr, 32'hA5A5_0000);

        // Randomized stalls, redirects and latencies
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(1, 4));
            t = $urandom;
            r = int'($urandom_range(0, 7));
            if (r == 0)      t = 32'hFFFF_FFFC;
            else if (r > 1)  t[1:0] = 2'b00;
            cycle(($urandom_range(0, 9) == 0), t,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
